fifo_fill_ctrl: RTL

Upstream fill controller for the `fifo_set` delay buffers in the matrix-feed path. It accepts a stream of BITS-wide words over a valid/ready handshake and collects INPUT_DEPTH of them into a staging array. It then issues a single parallel-load pulse (`wr_en` + `load_array`) into the downstream fifo. After the load it drives the fifo's shift enable for DEPTH cycles, so the loaded block comes out of the fifo in arrival order. The staging array is double-buffered: the next block fills while the current one drains.

---
 rtl/fifo_fill_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/fifo_fill_ctrl.sv
// rtl/fifo_fill_ctrl.sv - upstream fill controller: stages a block of words, parallel-loads it into a fifo_set, then drains it
//
// Collects INPUT_DEPTH words into a staging array over a valid/ready handshake.
// It issues one load strobe with the staged block, then shifts the downstream
// fifo DEPTH times. The next block keeps filling while the current one drains.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_data      upstream word; in_ready = staging has room
//   hold                  downstream stall, freezes shifting
//   wr_en, load_array     parallel-load strobe and staged block (index 0 = first word)
//   shift_en, shift_d     shift strobe and serial input (always 0)
//   q_valid               fifo q holds a loaded word and is consumed this cycle
//   busy                  block in flight or words staged
module fifo_fill_ctrl #(
    parameter int DEPTH       = 8,
    parameter int BITS        = 64,
    parameter int INPUT_DEPTH = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    input  logic [BITS-1:0]                   in_data,
    output logic                              in_ready,
    input  logic                              hold,
    output logic                              wr_en,
    output logic [INPUT_DEPTH-1:0][BITS-1:0]  load_array,
    output logic                              shift_en,
    output logic [BITS-1:0]                   shift_d,
    output logic                              q_valid,
    output logic                              busy
);

    localparam int FW = $clog2(INPUT_DEPTH + 1);
    localparam int SW = $clog2(DEPTH + 1);
    localparam logic [FW-1:0] FULL = FW'(INPUT_DEPTH);
    localparam logic [SW-1:0] LAST = SW'(DEPTH - 1);

    generate
        if (INPUT_DEPTH < 1 || INPUT_DEPTH > DEPTH) begin : g_bad_cfg
            $error("fifo_fill_ctrl: INPUT_DEPTH must be in 1..DEPTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t                            state;
    logic [FW-1:0]                     fill_cnt;
    logic [SW-1:0]                     sh_cnt;
    logic [INPUT_DEPTH-1:0][BITS-1:0]  staging;
    logic                              accept;
    logic                              q_window;

    assign accept = in_valid && in_ready;

    // The loaded block sits at the tail of the fifo, so only the last
    // INPUT_DEPTH shifts present loaded words on q. When the block fills the
    // whole fifo every shift does.
    generate
        if (DEPTH == INPUT_DEPTH) begin : g_full_window
            assign q_window = 1'b1;
        end else begin : g_tail_window
            localparam logic [SW-1:0] QSTART = SW'(DEPTH - INPUT_DEPTH);
            assign q_window = (sh_cnt >= QSTART);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            fill_cnt <= '0;
            sh_cnt   <= '0;
            staging  <= '0;
        end else begin
            // Staging fills independently of the FSM so the next block can
            // arrive while the current one is shifting out.
            if (accept) begin
                for (int i = 0; i < INPUT_DEPTH; i++) begin
                    if (fill_cnt == FW'(i)) begin
                        staging[i] <= in_data;
                    end
                end
            end

            // No word can be accepted in LOAD (staging is full), so clearing
            // here never drops an incoming word.
            if (state == LOAD) begin
                fill_cnt <= '0;
            end else if (accept) begin
                fill_cnt <= fill_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (fill_cnt == FULL) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    state  <= SHIFT;
                    sh_cnt <= '0;
                end
                SHIFT: begin
                    if (!hold) begin
                        sh_cnt <= sh_cnt + 1'b1;
                        if (sh_cnt == LAST) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready   = (fill_cnt < FULL);
    assign wr_en      = (state == LOAD);
    assign shift_en   = (state == SHIFT) && !hold;
    assign q_valid    = shift_en && q_window;
    assign busy       = (state != IDLE) || (fill_cnt != '0);
    assign load_array = staging;
    assign shift_d    = '0;

endmodule
